// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demux with per-channel one-deep output registers,
// broadcast mode and a saturating counter of words dropped on invalid select.

module demux_stream_chan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         free
);
    // A load wins over a pop so a same-cycle pop/push keeps the channel full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (valid && pop) begin
            valid <= 1'b0;
        end
    end

    assign free = ~valid | pop;
endmodule

module demux_stream_n #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 8,
    localparam int SW = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in_data,
    input  logic [SW-1:0]  in_sel,
    input  logic           in_bcast,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [CW-1:0]  drop_cnt
);
    localparam int NS = 1 << SW;
    localparam logic [SW:0] NV = (SW + 1)'(N);

    logic [N-1:0]  free;
    logic [N-1:0]  load;
    logic [NS-1:0] free_ext;
    logic          sel_ok;
    logic          accept;
    logic          drop;

    // Select codes past N-1 read as free so out-of-range words are always taken and dropped.
    always_comb begin
        free_ext        = '1;
        free_ext[N-1:0] = free;
    end

    assign sel_ok   = {1'b0, in_sel} < NV;
    assign in_ready = in_bcast ? &free : free_ext[in_sel];
    assign accept   = in_valid & in_ready;
    assign drop     = accept & ~in_bcast & ~sel_ok;

    for (genvar i = 0; i < N; i++) begin : g_chan
        assign load[i] = accept & (in_bcast | (in_sel == SW'(i)));

        demux_stream_chan #(.W(W)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .din   (in_data),
            .pop   (out_ready[i]),
            .data  (out_data[i*W +: W]),
            .valid (out_valid[i]),
            .free  (free[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_demux_stream_n.sv
// Directed checks plus a queue-model random run for demux_stream_n,
// using an N=4 instance and an N=3/CW=2 instance for the drop path.

module tb_demux_stream_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a_data;
    logic [1:0]  a_sel;
    logic        a_bcast, a_valid, a_ready;
    logic [31:0] a_odata;
    logic [3:0]  a_ovalid, a_oready;
    logic [7:0]  a_drop;

    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic        b_bcast, b_valid, b_ready;
    logic [23:0] b_odata;
    logic [2:0]  b_ovalid, b_oready;
    logic [1:0]  b_drop;

    demux_stream_n #(.N(4), .W(8), .CW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_bcast(a_bcast),
        .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid),
        .out_ready(a_oready), .drop_cnt(a_drop)
    );

    demux_stream_n #(.N(3), .W(8), .CW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
        .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid),
        .out_ready(b_oready), .drop_cnt(b_drop)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive dut_a inputs just after a falling edge.
    task automatic drive_a(input logic v, input logic [1:0] s, input logic bc, input logic [7:0] d,
                           input logic [3:0] rdy);
        @(negedge clk);
        a_valid = v; a_sel = s; a_bcast = bc; a_data = d; a_oready = rdy;
        #1;
    endtask

    task automatic edge_a;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q [4][$];
    logic [7:0] drop_exp [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

    initial begin
        a_data = '0; a_sel = '0; a_bcast = 1'b0; a_valid = 1'b0; a_oready = '1;
        b_data = '0; b_sel = '0; b_bcast = 1'b0; b_valid = 1'b0; b_oready = '1;
        #1;
        chk("rst_ovalid", 32'(a_ovalid), 32'h0);
        chk("rst_odata", a_odata, 32'h0);
        chk("rst_drop", 32'(a_drop), 32'h0);
        chk("rst_ready", 32'(a_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Consecutive words to channels 0..3 with all consumers ready.
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, 2'(k), 1'b0, 8'hA0 + 8'(k), 4'b1111);
            chk("t2_ready", 32'(a_ready), 32'h1);
            edge_a();
            chk("t2_ovalid", 32'(a_ovalid), 32'(4'b0001 << k));
            chk("t2_odata", 32'(a_odata[k*8 +: 8]), 32'hA0 + k);
        end
        drive_a(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        edge_a();
        chk("t2_drain", 32'(a_ovalid), 32'h0);

        // Stall channel 2, second word waits, then pop and push on one edge.
        drive_a(1'b1, 2'd2, 1'b0, 8'h11, 4'b1011);
        chk("t3_ready1", 32'(a_ready), 32'h1);
        edge_a();
        chk("t3_ovalid1", 32'(a_ovalid), 32'h4);
        chk("t3_data1", 32'(a_odata[23:16]), 32'h11);
        drive_a(1'b1, 2'd2, 1'b0, 8'h22, 4'b1011);
        chk("t3_ready2", 32'(a_ready), 32'h0);
        edge_a();
        chk("t3_hold_v", 32'(a_ovalid), 32'h4);
        chk("t3_hold_d", 32'(a_odata[23:16]), 32'h11);
        drive_a(1'b1, 2'd2, 1'b0, 8'h22, 4'b1111);
        chk("t3_ready3", 32'(a_ready), 32'h1);
        edge_a();
        chk("t3_ovalid2", 32'(a_ovalid), 32'h4);
        chk("t3_data2", 32'(a_odata[23:16]), 32'h22);
        drive_a(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        edge_a();
        chk("t3_drain", 32'(a_ovalid), 32'h0);

        // Broadcast blocked by stalled channel 1, then released.
        drive_a(1'b1, 2'd1, 1'b0, 8'h33, 4'b1101);
        edge_a();
        chk("t4_pre", 32'(a_ovalid), 32'h2);
        drive_a(1'b1, 2'd0, 1'b1, 8'h5C, 4'b1101);
        chk("t4_ready0", 32'(a_ready), 32'h0);
        edge_a();
        chk("t4_blk_v", 32'(a_ovalid), 32'h2);
        chk("t4_blk_d", a_odata, 32'hA3_22_33_A0);
        drive_a(1'b1, 2'd0, 1'b1, 8'h5C, 4'b1111);
        chk("t4_ready1", 32'(a_ready), 32'h1);
        edge_a();
        chk("t4_bc_v", 32'(a_ovalid), 32'hF);
        chk("t4_bc_d", a_odata, 32'h5C5C5C5C);
        drive_a(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        edge_a();
        chk("t4_drain", 32'(a_ovalid), 32'h0);

        // Invalid select on the N=3 instance; counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            b_valid = 1'b1; b_sel = 2'd3; b_bcast = 1'b0; b_data = 8'(k);
            #1;
            chk("t5_ready", 32'(b_ready), 32'h1);
            edge_a();
            chk("t5_ovalid", 32'(b_ovalid), 32'h0);
            chk("t5_drop", 32'(b_drop), 32'(drop_exp[k]));
        end
        @(negedge clk);
        b_valid = 1'b0;
        chk("t5_a_drop", 32'(a_drop), 32'h0);

        // Asynchronous reset mid-stream.
        drive_a(1'b1, 2'd0, 1'b0, 8'h77, 4'b0000);
        edge_a();
        chk("t1_pre", 32'(a_ovalid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_ovalid", 32'(a_ovalid), 32'h0);
        chk("t1_odata", a_odata, 32'h0);
        chk("t1_drop", 32'(b_drop), 32'h0);
        chk("t1_ready", 32'(a_ready), 32'h1);
        edge_a();
        chk("t1_noxfer", 32'(a_ovalid), 32'h0);
        @(negedge clk);
        a_valid = 1'b0;
        rst_n = 1'b1;

        // Random traffic against a per-channel queue model.
        for (int c = 0; c < 10000; c++) begin
            logic [3:0] fr;
            logic       er;
            @(negedge clk);
            a_valid  = ($urandom_range(0, 3) != 0);
            a_sel    = 2'($urandom_range(0, 3));
            a_bcast  = ($urandom_range(0, 7) == 0);
            a_data   = 8'($urandom);
            a_oready = 4'($urandom);
            #1;
            for (int i = 0; i < 4; i++) begin
                chk("rnd_valid", 32'(a_ovalid[i]), 32'(q[i].size() != 0));
                if (q[i].size() != 0)
                    chk("rnd_data", 32'(a_odata[i*8 +: 8]), 32'(q[i][0]));
                fr[i] = (q[i].size() == 0) || a_oready[i];
            end
            er = a_bcast ? &fr : fr[a_sel];
            chk("rnd_ready", 32'(a_ready), 32'(er));
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() != 0 && a_oready[i]) void'(q[i].pop_front());
                if (a_valid && er && (a_bcast || a_sel == 2'(i))) q[i].push_back(a_data);
            end
        end
        #1;
        chk("rnd_drop", 32'(a_drop), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
